// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM state encoding, reset/halt constants and the
// fetch buffer entry layout.
package cpu_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] HALT_INST_DEF = 32'hFC00_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer. The head lives in its own register so decode sees
// registered outputs only; flush discards everything after any same-cycle pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    fetch_entry_t head_q, tail_q;
    logic [1:0]   count_q;

    assign dout  = head_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= din;
                    else                 tail_q <= din;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (count_q == FULL_CNT) begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end else begin
                        head_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, pushes {pc, inst} into a 2-entry buffer, handles
// redirect flushes and halt. Define FETCH_PERF_EN to add fetch/stall counters.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HALT_INST  = HALT_INST_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
`ifdef FETCH_PERF_EN
    input  logic        perf_clr,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic        halted
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    fetch_entry_t head, din;
    logic         full, empty, pop, push;

    assign pop  = out_valid && out_ready;
    assign push = (state_q == RUN) && !redir_valid && (!full || pop);
    assign din  = '{pc: pc_q, inst: imem_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else if (redir_valid) begin
            state_q <= RUN;
            pc_q    <= redir_pc & ~32'h3;
        end else if (push) begin
            // The halt word is still delivered; the PC parks on it.
            if (imem_data == HALT_INST) state_q <= HALT;
            else                        pc_q    <= pc_q + 32'd4;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .flush (redir_valid),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign imem_addr = pc_q;
    assign out_valid = !empty;
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;
    assign halted    = (state_q == HALT);

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else if (perf_clr) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if ((state_q == RUN) && full && !pop) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, back-pressure, redirect, halt,
// PC wrap, asynchronous reset and (when FETCH_PERF_EN) the perf counters.
module tb_fetch_ctrl;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] imem_addr, imem_data, redir_pc, out_inst, out_pc;
    logic        redir_valid = 0, out_valid, out_ready = 0, halted;
    logic [31:0] mem [64];
    int          checks = 0, failures = 0;
`ifdef FETCH_PERF_EN
    logic        perf_clr = 0;
    logic [31:0] perf_fetched, perf_stall;
`endif

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr[7:2]];

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
`ifdef FETCH_PERF_EN
        .perf_clr    (perf_clr),
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall),
`endif
        .halted      (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | i;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h200A_0003;
    endtask

    task automatic do_reset(input logic rdy);
        rst_n = 0; redir_valid = 0; redir_pc = 0; out_ready = rdy;
        step(); step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        fill_mem();
        do_reset(1'b1);
        rst_n = 0; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin failures++; $display("FAIL reset_out got=%h/%h exp=0/0", out_pc, out_inst); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc = '{32'h0, 32'h4, 32'h8};
        exp_in = '{32'h2008_0001, 32'h2009_0002, 32'h200A_0003};
        fill_mem();
        do_reset(1'b1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_lat0 got=%b exp=0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_inst !== exp_in[i]) begin
                failures++;
                $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", i, out_valid, out_pc, out_inst, exp_pc[i], exp_in[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        fill_mem();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step();
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL bp_addr got=%h exp=8", imem_addr); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/0", out_valid, out_pc); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i]) begin
                failures++;
                $display("FAIL bp_drain_%0d got=%b/%h exp=1/%h", i, out_valid, out_pc, exp_pc[i]);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        fill_mem();
        do_reset(1'b0);
        step(); step();
        out_ready = 1; redir_valid = 1; redir_pc = 32'h0000_0043;
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL redir_pop got=%h exp=0", out_pc); end
        step();
        redir_valid = 0;
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin failures++; $display("FAIL redir_flush got=%b/%h exp=0/40", out_valid, imem_addr); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h2000_0010) begin failures++; $display("FAIL redir_first got=%b/%h/%h exp=1/40/20000010", out_valid, out_pc, out_inst); end
    endtask

    task automatic test_halt();
        fill_mem();
        mem[4] = 32'hFC00_0000;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) step();
        checks++; if (out_pc !== 32'h10 || out_inst !== 32'hFC00_0000) begin failures++; $display("FAIL halt_entry got=%h/%h exp=10/fc000000", out_pc, out_inst); end
        checks++; if (halted !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL halt_state got=%b/%h exp=1/10", halted, imem_addr); end
        step();
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h10 || halted !== 1'b1) begin failures++; $display("FAIL halt_hold got=%b/%h/%b exp=0/10/1", out_valid, imem_addr, halted); end
        redir_valid = 1; redir_pc = 32'h0;
        step();
        redir_valid = 0;
        checks++; if (halted !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL halt_resume got=%b/%h exp=0/0", halted, imem_addr); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL halt_refetch got=%b/%h exp=1/0", out_valid, out_pc); end
    endtask

    task automatic test_wrap();
        fill_mem();
        do_reset(1'b1);
        redir_valid = 1; redir_pc = 32'hFFFF_FFFC;
        step();
        redir_valid = 0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
        step();
        checks++; if (out_pc !== 32'hFFFF_FFFC || out_inst !== 32'h2000_003F) begin failures++; $display("FAIL wrap_last got=%h/%h exp=fffffffc/2000003f", out_pc, out_inst); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL wrap_zero got=%b/%h exp=1/0", out_valid, out_pc); end
    endtask

    task automatic test_async_reset();
        fill_mem();
        do_reset(1'b1);
        step(); step(); step();
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0) begin failures++; $display("FAIL async_rst got=%b/%h/%h exp=0/0/0", out_valid, imem_addr, out_pc); end
        step();
        rst_n = 1;
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        fill_mem();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step();
        out_ready = 1;
        step(); step();
        out_ready = 0;
        checks++; if (perf_fetched !== 32'd4 || perf_stall !== 32'd3) begin failures++; $display("FAIL perf_cnt got=%0d/%0d exp=4/3", perf_fetched, perf_stall); end
        perf_clr = 1;
        step();
        perf_clr = 0;
        checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin failures++; $display("FAIL perf_clr got=%0d/%0d exp=0/0", perf_fetched, perf_stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
